// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, depth helper and read-mode encoding for sync_fifo_flags
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  typedef enum logic {RD_REGISTERED = 1'b0, RD_FWFT = 1'b1} read_mode_e;
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
  function automatic read_mode_e read_mode(input int fwft);
    return fwft != 0 ? RD_FWFT : RD_REGISTERED;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-port array, synchronous write, asynchronous read
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] mem_q [depth_of(ADDR_WIDTH)];
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_waddr] <= i_wdata;
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, programmable thresholds and sticky error flags
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FWFT       = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_winc,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rinc,
  input  logic                  i_clr_err,
  input  logic [ADDR_WIDTH:0]   i_afull_thresh,
  input  logic [ADDR_WIDTH:0]   i_aempty_thresh,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam read_mode_e MODE = read_mode(FWFT);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
  logic [ADDR_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, rvalid_q, rvalid_d, push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rdata;
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .i_clk  (i_clk),
    .i_we   (push_ok),
    .i_waddr(wptr_q[ADDR_WIDTH-1:0]),
    .i_wdata(i_wdata),
    .i_raddr(rptr_q[ADDR_WIDTH-1:0]),
    .o_rdata(mem_rdata)
  );
  assign o_full         = count_q == CNT_FULL;
  assign o_empty        = count_q == '0;
  assign o_almost_full  = count_q >= i_afull_thresh;
  assign o_almost_empty = count_q <= i_aempty_thresh;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
  assign o_rdata        = MODE == RD_FWFT ? mem_rdata : rdata_q;
  assign o_rvalid       = MODE == RD_FWFT ? !o_empty : rvalid_q;
  // a full FIFO still accepts a push when a pop frees the head slot in the same cycle
  always_comb begin
    pop_ok   = i_rinc && !o_empty;
    push_ok  = i_winc && (!o_full || pop_ok);
    wptr_d   = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop_ok ? rptr_q + 1'b1 : rptr_q;
    count_d  = push_ok && !pop_ok ? count_q + 1'b1 :
               pop_ok && !push_ok ? count_q - 1'b1 : count_q;
    ovf_d    = (i_winc && !push_ok) || (ovf_q && !i_clr_err);
    unf_d    = (i_rinc && o_empty) || (unf_q && !i_clr_err);
    rvalid_d = pop_ok;
    rdata_d  = pop_ok ? mem_rdata : rdata_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: FWFT and registered builds driven in lockstep against a queue model
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, winc, rinc, clr;
  logic [7:0] wdata;
  logic [4:0] afth, aeth;
  logic [7:0] f_rdata, r_rdata;
  logic [4:0] f_count, r_count;
  logic f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic r_rvalid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_winc(winc), .i_wdata(wdata), .i_rinc(rinc),
    .i_clr_err(clr), .i_afull_thresh(afth), .i_aempty_thresh(aeth),
    .o_rdata(f_rdata), .o_rvalid(f_rvalid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );
  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_winc(winc), .i_wdata(wdata), .i_rinc(rinc),
    .i_clr_err(clr), .i_afull_thresh(afth), .i_aempty_thresh(aeth),
    .o_rdata(r_rdata), .o_rvalid(r_rvalid), .o_full(r_full), .o_empty(r_empty),
    .o_almost_full(r_af), .o_almost_empty(r_ae), .o_count(r_count),
    .o_overflow(r_ovf), .o_underflow(r_unf)
  );
  typedef struct {
    logic w; logic [7:0] d; logic r; logic c;
    int cnt; logic ovf; logic unf;
  } vec_t;
  vec_t vt[8];
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0, m_rv = 1'b0;
  logic [7:0] m_rd = 8'h00;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    chk("f_count", f_count, n);
    chk("f_full", f_full, n == 16);
    chk("f_empty", f_empty, n == 0);
    chk("f_almost_full", f_af, n >= int'(afth));
    chk("f_almost_empty", f_ae, n <= int'(aeth));
    chk("f_overflow", f_ovf, m_ovf);
    chk("f_underflow", f_unf, m_unf);
    chk("f_rvalid", f_rvalid, n > 0);
    if (n > 0) chk("f_rdata", f_rdata, q[0]);
    chk("r_count", r_count, n);
    chk("r_full", r_full, n == 16);
    chk("r_empty", r_empty, n == 0);
    chk("r_almost_full", r_af, n >= int'(afth));
    chk("r_almost_empty", r_ae, n <= int'(aeth));
    chk("r_overflow", r_ovf, m_ovf);
    chk("r_underflow", r_unf, m_unf);
    chk("r_rvalid", r_rvalid, m_rv);
    chk("r_rdata", r_rdata, m_rd);
  endtask
  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv = 1'b0;
    m_rd = 8'h00;
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic push_ok, pop_ok;
    winc = w; wdata = d; rinc = r; clr = c;
    pop_ok = r && q.size() > 0;
    push_ok = w && (q.size() < 16 || pop_ok);
    @(posedge clk);
    #1;
    m_ovf = (w && !push_ok) || (m_ovf && !c);
    m_unf = (r && q.size() == 0) || (m_unf && !c);
    m_rv = pop_ok;
    if (pop_ok) m_rd = q.pop_front();
    if (push_ok) q.push_back(d);
    check_all();
  endtask
  initial begin
    rst_n = 1'b0; winc = 0; rinc = 0; clr = 0; wdata = 0;
    afth = 5'd12; aeth = 5'd3;
    #12;
    check_all();
    afth = 5'd0;
    #1;
    chk("reset_afull_thresh0", f_af, 1'b1);
    afth = 5'd12;
    rst_n = 1'b1;
    vt[0] = '{1, 8'h11, 1, 0, 1, 0, 1};
    vt[1] = '{0, 8'h00, 0, 1, 1, 0, 0};
    vt[2] = '{1, 8'h22, 0, 0, 2, 0, 0};
    vt[3] = '{0, 8'h00, 1, 0, 1, 0, 0};
    vt[4] = '{0, 8'h00, 1, 0, 0, 0, 0};
    vt[5] = '{0, 8'h00, 1, 0, 0, 0, 1};
    vt[6] = '{0, 8'h00, 1, 1, 0, 0, 1};
    vt[7] = '{0, 8'h00, 0, 1, 0, 0, 0};
    foreach (vt[i]) begin
      step(vt[i].w, vt[i].d, vt[i].r, vt[i].c);
      chk($sformatf("vec%0d_count", i), f_count, vt[i].cnt);
      chk($sformatf("vec%0d_ovf", i), f_ovf, vt[i].ovf);
      chk($sformatf("vec%0d_unf", i), f_unf, vt[i].unf);
    end
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", f_full, 1'b1);
    chk("fill_count", f_count, 5'd16);
    step(1, 8'hAA, 0, 0);
    chk("overflow_set", f_ovf, 1'b1);
    step(0, 8'h00, 0, 1);
    chk("overflow_clr", f_ovf, 1'b0);
    step(1, 8'h55, 1, 0);
    chk("full_pushpop_head", r_rdata, 8'h00);
    chk("full_pushpop_count", f_count, 5'd16);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    chk("drain_tail55", r_rdata, 8'h55);
    chk("drain_empty", f_empty, 1'b1);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("reg_first", r_rdata, 8'h22);
    step(0, 8'h00, 1, 0);
    chk("reg_second", r_rdata, 8'h33);
    step(0, 8'h00, 0, 0);
    chk("reg_pulse_end", r_rvalid, 1'b0);
    chk("reg_hold", r_rdata, 8'h33);
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        afth = 5'($urandom_range(0, 31));
        aeth = 5'($urandom_range(0, 31));
      end
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 15) == 0);
    end
    afth = 5'd12; aeth = 5'd3;
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 4, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
